uart_tx: RTL and testbench

//  UART transmitter, the outgoing partner of uart_rx. Serialises one byte per frame:
//  1 start bit (0), DATA_WIDTH data bits LSB first, stop period (1), no parity.
//  Bit timing comes from a uart_tick_gen instance giving 16 ticks per bit, so rx and tx

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-source handshake between the core and the UART transmitter.
// Signal names carry the transmitter's point of view (i_ into tx, o_ out of tx).
interface uart_tx_if;
  logic       i_valid;
  logic [7:0] i_data_byte;
  logic       o_ready;

  modport slave (
    input  i_valid,
    input  i_data_byte,
    output o_ready
  );

  modport master (
    output i_valid,
    output i_data_byte,
    input  o_ready
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, SB_TICK-tick stop period.
// Bit timing comes from a free-running 16x oversampling tick generator.
module uart_tick_gen (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_div,
  output logic        o_tick
);
  logic [10:0] cnt_q;
  logic        tick_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == i_div) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 11'd1;
      tick_q <= 1'b0;
    end
  end

  assign o_tick = tick_q;
endmodule

module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SB_TICK    = 16,
  parameter int DIV        = 95
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_tx_if.slave tx_if,
  output logic     o_tx,
  output logic     o_busy,
  output logic     o_done
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [4:0] TICK_LAST = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_WIDTH - 1);

  state_t     state_q, state_d;
  logic [4:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       tick;
  logic       handshake;

  uart_tick_gen u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_div   (11'(DIV)),
    .o_tick  (tick)
  );

  assign handshake = tx_if.i_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A tick coinciding with the handshake is deliberately not counted.
        if (handshake) begin
          shift_d    = tx_if.i_data_byte;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            state_d    = DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == BIT_LAST) state_d = STOP;
            else                       bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt_q == STOP_LAST) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            done_d     = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    // Holding ready low on the STOP->IDLE cycle makes it rise the cycle after o_done.
    ready_d = (state_q == IDLE) && (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign o_tx          = tx_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign tx_if.o_ready = ready_q;
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 and 7-bit/2-stop instances, frame timing checked
// against the measured tick period.
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tx8, busy8, done8, tx7, busy7, done7;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   T = 4;

  uart_tx_if if8 ();
  uart_tx_if if7 ();

  uart_tx #(.DATA_WIDTH(8), .SB_TICK(16), .DIV(3)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .tx_if(if8.slave),
    .o_tx(tx8), .o_busy(busy8), .o_done(done8)
  );

  uart_tx #(.DATA_WIDTH(7), .SB_TICK(32), .DIV(3)) dut7 (
    .i_clk(clk), .i_rst_n(rst_n), .tx_if(if7.slave),
    .o_tx(tx7), .o_busy(busy7), .o_done(done7)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    logic [7:0] data;
    int         nb;
    int         sb;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx7 : tx8;
  endfunction

  function automatic logic cur_done(input bit sel);
    return sel ? done7 : done8;
  endfunction

  function automatic logic cur_ready(input bit sel);
    return sel ? if7.o_ready : if8.o_ready;
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [7:0] b);
    if (sel) begin
      if7.i_valid = v; if7.i_data_byte = b;
    end else begin
      if8.i_valid = v; if8.i_data_byte = b;
    end
  endtask

  // Offers a byte and returns just after the accepting rising edge; valid stays high.
  task automatic drive_byte(input bit sel, input logic [7:0] b);
    int w;
    @(negedge clk);
    set_in(sel, 1'b1, b);
    w = 0;
    while (!cur_ready(sel) && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 4000) fail_now("handshake");
    @(posedge clk);
  endtask

  task automatic release_valid(input bit sel);
    @(negedge clk);
    set_in(sel, 1'b0, 8'h00);
  endtask

  // Records o_tx each cycle from the start-bit fall to o_done, then checks each bit
  // window counted back from o_done. w_out = cycles waited for the start bit.
  task automatic capture(input bit sel, input int nb, input int sb,
                         input logic [9:0] exp, input string nm, output int w_out);
    bit hist[2048];
    int w, idx, d, slen, base, bad;
    bit seen;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (cur_tx(sel) !== 1'b0 && w < 5000);
    w_out = w;
    if (w >= 5000) begin
      fail_now({nm, "_start"});
      return;
    end
    idx = 0;
    hist[0] = 1'b0;
    seen = 1'b0;
    while (!seen && idx < 2000) begin
      @(negedge clk);
      idx++;
      hist[idx] = cur_tx(sel);
      seen = cur_done(sel);
    end
    if (!seen) begin
      fail_now({nm, "_done"});
      return;
    end
    d = idx;
    slen = d - sb * T - nb * 16 * T;
    chk_rng({nm, "_start_len"}, slen, 15 * T, 17 * T);
    if (slen < 1) return;
    for (int i = 0; i < nb; i++) begin
      base = slen + i * 16 * T;
      bad = 0;
      for (int j = 0; j < 16 * T; j++)
        if (hist[base + j] !== exp[i + 1]) bad++;
      chk($sformatf("%s_bit%0d_bad_cycles", nm, i), bad, 0);
    end
    bad = 0;
    for (int j = d - sb * T; j < d; j++)
      if (hist[j] !== 1'b1) bad++;
    chk({nm, "_stop_bad_cycles"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, t0, t1, cnt;
    set_in(1'b0, 1'b0, 8'h00);
    set_in(1'b1, 1'b0, 8'h00);

    tbl[0] = '{sel: 1'b0, data: 8'hA5, nb: 8, sb: 16, exp: 10'b1101001010};
    tbl[1] = '{sel: 1'b0, data: 8'h00, nb: 8, sb: 16, exp: 10'b1000000000};
    tbl[2] = '{sel: 1'b0, data: 8'hFF, nb: 8, sb: 16, exp: 10'b1111111110};
    tbl[3] = '{sel: 1'b1, data: 8'hFF, nb: 7, sb: 32, exp: 10'b0111111110};
    tbl[4] = '{sel: 1'b0, data: 8'h55, nb: 8, sb: 16, exp: 10'b1010101010};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx8, 1);
    chk("rst_ready", if8.o_ready, 1);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_tx7", tx7, 1);
    chk("rst_busy7", busy7, 0);
    rst_n = 1'b1;

    // Measure the tick period from two consecutive intervals.
    w = 0;
    while (dut8.u_tick.o_tick !== 1'b1 && w < 200) begin @(negedge clk); w++; end
    t0 = 0;
    do begin @(negedge clk); t0++; end while (dut8.u_tick.o_tick !== 1'b1 && t0 < 200);
    t1 = 0;
    do begin @(negedge clk); t1++; end while (dut8.u_tick.o_tick !== 1'b1 && t1 < 200);
    chk_rng("tick_period", t0, 1, 100);
    chk("tick_period_stable", t1, t0);
    T = t0;

    for (int k = 0; k < 5; k++) begin
      fork
        capture(tbl[k].sel, tbl[k].nb, tbl[k].sb, tbl[k].exp, $sformatf("vec%0d", k), w);
        begin
          drive_byte(tbl[k].sel, tbl[k].data);
          release_valid(tbl[k].sel);
        end
      join
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", k), cur_done(tbl[k].sel), 0);
      chk($sformatf("vec%0d_ready_after", k), cur_ready(tbl[k].sel), 1);
    end

    // Valid pulsed mid-frame must be ignored.
    fork
      capture(1'b0, 8, 16, 10'b1101001010, "ignore", w);
      begin
        drive_byte(1'b0, 8'hA5);
        release_valid(1'b0);
        repeat (200) @(negedge clk);
        chk("ignore_ready_low", if8.o_ready, 0);
        set_in(1'b0, 1'b1, 8'h3C);
        repeat (3) @(negedge clk);
        set_in(1'b0, 1'b0, 8'h00);
      end
    join
    cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || busy8 !== 1'b0) cnt++;
    end
    chk("ignore_no_extra_frame", cnt, 0);

    // Back-to-back frames with valid held high.
    fork
      begin
        capture(1'b0, 8, 16, 10'b1000000000, "b2b0", w);
        capture(1'b0, 8, 16, 10'b1111111110, "b2b1", w);
        chk_rng("b2b_gap1", w, 1, 2);
        capture(1'b0, 8, 16, 10'b1010101010, "b2b2", w);
        chk_rng("b2b_gap2", w, 1, 2);
      end
      begin
        drive_byte(1'b0, 8'h00);
        drive_byte(1'b0, 8'hFF);
        drive_byte(1'b0, 8'h55);
        release_valid(1'b0);
      end
    join
    cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx8 !== 1'b1) cnt++;
    end
    chk("b2b_no_duplicate", cnt, 0);

    // Asynchronous reset in the middle of the data bits.
    drive_byte(1'b0, 8'h00);
    release_valid(1'b0);
    repeat (48 * T) @(negedge clk);
    chk("rst_mid_tx_low", tx8, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx_async", tx8, 1);
    chk("rst_mid_busy", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    fork
      capture(1'b0, 8, 16, 10'b1100000010, "after_rst", w);
      begin
        drive_byte(1'b0, 8'h81);
        release_valid(1'b0);
      end
    join
    @(negedge clk);
    chk("after_rst_ready", if8.o_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
